// File: rtl/counter_sched_pkg.sv
// Shared types and the round-robin pick helper for the counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam int MAX_REQ   = 8;
  localparam int PTR_MAX_W = 3;

  // Lowest index at or after ptr (cyclic over n requesters) wins; only bits < n are considered.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                 input logic [PTR_MAX_W-1:0] ptr,
                                                 input int                   n);
    logic [MAX_REQ-1:0]   g;
    logic [PTR_MAX_W-1:0] idx;
    logic                 found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = PTR_MAX_W'((int'(ptr) + i) % n);
      if (i < n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Client-facing bundle of the counter scheduler: requests, lengths and grant/status.
interface counter_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;
  logic                     abort;
  logic [CNT_W-1:0]         count;

  modport master (output req, len, input gnt, busy, done, abort, count);
  modport slave  (input req, len, output gnt, busy, done, abort, count);
endinterface

// File: rtl/counter_sched_counter_core.sv
// Plain up-counter with synchronous clear and enable; clear dominates enable.
module counter_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up-counter between NUM_REQ requesters.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  counter_sched_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_abort;
  logic [CNT_W-1:0]   r_len_q;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_rr_ptr;

  sched_state_t       w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic               w_abort_nxt;
  logic [CNT_W-1:0]   w_len_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_clr;
  logic               w_en;

  logic [MAX_REQ-1:0]   w_req_ext;
  logic [PTR_MAX_W-1:0] w_ptr_ext;
  logic [MAX_REQ-1:0]   w_pick_ext;
  logic [NUM_REQ-1:0]   w_pick;
  logic                 w_pick_any;
  logic [CNT_W-1:0]     w_pick_len;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [PTR_W-1:0]     w_owner_inc;
  logic [CNT_W-1:0]     w_count;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = bus.req;
    w_ptr_ext                = '0;
    w_ptr_ext[PTR_W-1:0]     = r_rr_ptr;
  end

  assign w_pick_ext = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
  assign w_pick     = w_pick_ext[NUM_REQ-1:0];
  // The picker only sets bits below NUM_REQ, so its OR is "any request pending".
  assign w_pick_any = |w_pick_ext;

  always_comb begin
    w_pick_len = '0;
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_len = bus.len[i*CNT_W +: CNT_W];
        w_pick_idx = PTR_W'(i);
      end
    end
  end

  assign w_owner_inc = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_abort_nxt = 1'b0;
    w_len_nxt   = r_len_q;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_rr_ptr;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (w_pick_any) begin
          w_gnt_nxt   = w_pick;
          w_len_nxt   = w_pick_len;
          w_owner_nxt = w_pick_idx;
          // A zero-length request completes immediately without counting.
          if (w_pick_len == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = w_pick;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_abort_nxt = 1'b1;
          w_clr       = 1'b1;
          w_ptr_nxt   = w_owner_inc;
        end else if (w_count == r_len_q - CNT_W'(1)) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_gnt;
        end else begin
          w_en = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_clr       = 1'b1;
        w_ptr_nxt   = w_owner_inc;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_clr       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_abort  <= 1'b0;
      r_len_q  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_abort  <= w_abort_nxt;
      r_len_q  <= w_len_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  counter_core #(
    .CNT_W (CNT_W)
  ) u_counter_core (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count)
  );

  assign bus.gnt   = r_gnt;
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;
  assign bus.abort = r_abort;
  assign bus.count = w_count;

endmodule
